// File: rtl/axis_bram_player.sv
// axis_bram_player
//
// Streams a block of words from port A of a dual-port BRAM onto an AXI4-Stream
// master. Each pass reads cfg_data+1 words starting at address 0. With cfg_loop
// set, passes repeat back to back until cfg_loop is cleared. The one-cycle BRAM
// read latency is hidden behind a two-entry output buffer, so with tready held
// high the block sustains one word per clock.
//
// Ports:
//   aclk, areset           clock and asynchronous active-high reset
//   cfg_data               last address of a pass (inclusive)
//   cfg_loop               restart at address 0 after each pass
//   trg_start              start pulse, honoured only while idle
//   sts_data               next BRAM address to be issued
//   sts_busy               high whenever the block is not idle
//   m_axis_*               AXI4-Stream master (tdata, tvalid, tready, tlast)
//   bram_porta_*           BRAM read port (clk, rst, en, addr, rddata)
module axis_bram_player #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int BRAM_DATA_WIDTH  = 32,
  parameter int BRAM_ADDR_WIDTH  = 10
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [BRAM_ADDR_WIDTH-1:0]  cfg_data,
  input  logic                        cfg_loop,
  input  logic                        trg_start,
  output logic [BRAM_ADDR_WIDTH-1:0]  sts_data,
  output logic                        sts_busy,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  output logic                        bram_porta_clk,
  output logic                        bram_porta_rst,
  output logic                        bram_porta_en,
  output logic [BRAM_ADDR_WIDTH-1:0]  bram_porta_addr,
  input  logic [BRAM_DATA_WIDTH-1:0]  bram_porta_rddata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                       state;
  logic [BRAM_ADDR_WIDTH-1:0]   addr;
  logic [BRAM_ADDR_WIDTH-1:0]   len;

  // Two-entry output buffer, addressed as a tiny circular FIFO.
  logic [AXIS_TDATA_WIDTH-1:0]  buf_data [2];
  logic [1:0]                   buf_last;
  logic                         wr_ptr;
  logic                         rd_ptr;
  logic [1:0]                   count;

  // One read can be outstanding in the BRAM pipeline at a time per cycle.
  logic                         inflight;
  logic                         inflight_last;

  logic                         accept;
  logic                         issue;
  logic                         issue_last;
  logic [2:0]                   pending;

  assign m_axis_tvalid = (count != 2'd0);
  assign m_axis_tdata  = buf_data[rd_ptr];
  assign m_axis_tlast  = m_axis_tvalid & buf_last[rd_ptr];
  assign accept        = m_axis_tvalid & m_axis_tready;

  // A read may be issued only if the word it returns is guaranteed a buffer
  // slot: words held plus words in flight, less the one leaving this cycle,
  // must be below the buffer depth. Counting the departing word lets issue
  // resume in the same cycle tready returns and keeps back-to-back flow.
  always_comb begin
    pending    = {1'b0, count} + {2'b00, inflight} - {2'b00, accept};
    issue      = (state == RUN) && (pending < 3'd2);
    issue_last = (addr == len);
  end

  assign bram_porta_clk  = aclk;
  assign bram_porta_rst  = areset;
  assign bram_porta_en   = issue;
  assign bram_porta_addr = addr;
  assign sts_data        = addr;
  assign sts_busy        = (state != IDLE);

  // Control FSM and address counter. The pass length is latched at trigger and
  // again at every loop wrap, so cfg_data edits mid-pass only take effect at
  // the next pass boundary. A non-looping pass leaves the counter one past the
  // last address, which wraps to 0 for a full-buffer pass.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state <= IDLE;
      addr  <= '0;
      len   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (trg_start) begin
            state <= RUN;
            addr  <= '0;
            len   <= cfg_data;
          end
        end
        RUN: begin
          if (issue) begin
            if (issue_last) begin
              if (cfg_loop) begin
                addr <= '0;
                len  <= cfg_data;
              end else begin
                addr  <= addr + 1'b1;
                state <= DRAIN;
              end
            end else begin
              addr <= addr + 1'b1;
            end
          end
        end
        DRAIN: begin
          if ((count == 2'd0) && !inflight) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read pipeline and output buffer. A read issued this cycle returns its data
  // on the next cycle, where it is written into the buffer together with the
  // last-address tag captured at issue time.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      buf_data[0]   <= '0;
      buf_data[1]   <= '0;
      buf_last      <= 2'b00;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      count         <= 2'd0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue_last;
      if (inflight) begin
        buf_data[wr_ptr] <= bram_porta_rddata;
        buf_last[wr_ptr] <= inflight_last;
        wr_ptr           <= ~wr_ptr;
      end
      if (accept) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, inflight} - {1'b0, accept};
    end
  end

endmodule
